// File: rtl/exu_muldiv.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up applied once when the result is formed.
module exu_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_src1,
   input  logic [WIDTH-1:0] i_src2,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_res,
   output logic             o_dbz
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             neg_q, neg_d;
   logic             nrem_q, nrem_d;
   logic             byp_q, byp_d;
   logic             dbz_q, dbz_d;

   // Request decode: which operands are signed, their magnitudes, special cases
   logic             is_div, s1_signed, s2_signed, a_neg, b_neg, src2_zero, ovf;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign is_div    = i_op[2];
   assign s1_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
   assign s2_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
   assign a_neg     = s1_signed & i_src1[WIDTH-1];
   assign b_neg     = s2_signed & i_src2[WIDTH-1];
   assign a_mag     = a_neg ? -i_src1 : i_src1;
   assign b_mag     = b_neg ? -i_src2 : i_src2;
   assign src2_zero = (i_src2 == '0);
   assign ovf       = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                      (i_src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_src2);

   // One iteration of each algorithm; {hi,lo} is the shared working register
   logic [WIDTH:0]   add, shl, trial;
   logic             ge;
   logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

   assign add    = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
   assign mul_hi = add[WIDTH:1];
   assign mul_lo = {add[0], lo_q[WIDTH-1:1]};
   assign shl    = {hi_q, lo_q[WIDTH-1]};
   assign trial  = shl - {1'b0, b_q};
   assign ge     = ~trial[WIDTH];
   assign div_hi = ge ? trial[WIDTH-1:0] : shl[WIDTH-1:0];
   assign div_lo = {lo_q[WIDTH-2:0], ge};

   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quo, rem, fin_res;

   assign prod   = {hi_q, lo_q};
   assign prod_s = neg_q ? -prod : prod;
   assign quo    = neg_q ? -lo_q : lo_q;
   assign rem    = nrem_q ? -hi_q : hi_q;

   always_comb begin
      fin_res = '0;
      case (op_q)
         OP_MUL:                        fin_res = prod_s[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_s[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:               fin_res = quo;
         OP_REM, OP_REMU:               fin_res = rem;
         default:                       fin_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      res_d   = res_q;
      neg_d   = neg_q;
      nrem_d  = nrem_q;
      byp_d   = byp_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               state_d = S_CALC;
               op_d    = i_op;
               neg_d   = a_neg ^ b_neg;
               nrem_d  = a_neg;
               hi_d    = '0;
               lo_d    = is_div ? a_mag : b_mag;
               b_d     = is_div ? b_mag : a_mag;
               res_d   = '0;
               dbz_d   = 1'b0;
               byp_d   = 1'b0;
               cnt_d   = CNT_W'(WIDTH);
               // Special divides skip the iterations; counter 0 finishes next cycle
               if (is_div && src2_zero) begin
                  byp_d = 1'b1;
                  dbz_d = 1'b1;
                  cnt_d = '0;
                  res_d = i_op[1] ? i_src1 : '1;
               end else if (ovf) begin
                  byp_d = 1'b1;
                  cnt_d = '0;
                  res_d = i_op[1] ? '0 : i_src1;
               end
            end
         end
         S_CALC: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
               if (!byp_q) res_d = fin_res;
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               hi_d  = op_q[2] ? div_hi : mul_hi;
               lo_d  = op_q[2] ? div_lo : mul_lo;
            end
         end
         S_DONE: begin
            if (i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (i_flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         res_d   = '0;
         dbz_d   = 1'b0;
         byp_d   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         res_q   <= '0;
         neg_q   <= 1'b0;
         nrem_q  <= 1'b0;
         byp_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         res_q   <= res_d;
         neg_q   <= neg_d;
         nrem_q  <= nrem_d;
         byp_q   <= byp_d;
         dbz_q   <= dbz_d;
      end
   end

   assign o_ready = (state_q == S_IDLE);
   assign o_valid = (state_q == S_DONE);
   assign o_res   = o_valid ? res_q : '0;
   assign o_dbz   = o_valid & dbz_q;

endmodule
